// File: rtl/dst_fifo.sv
// AXI-Stream FIFO between the hypervector engine and the DMA S2MM channel.
// Optional store-and-forward mode selected by macro DST_FIFO_STORE_FWD_EN.
module dst_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  AXIS_ACLK,
  input  logic                  AXIS_ARESETN,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [63:0]           S_AXIS_TDATA,
  input  logic [7:0]            S_AXIS_TSTRB,
  input  logic                  S_AXIS_TLAST,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic [63:0]           M_AXIS_TDATA,
  output logic [7:0]            M_AXIS_TSTRB,
  output logic                  M_AXIS_TLAST,
  output logic [DEPTH_LOG2:0]   level,
  output logic [CNT_W-1:0]      pkt_cnt,
  output logic                  sf_stall
);

  localparam int                  DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] LVL_ZERO = (DEPTH_LOG2+1)'(0);
  localparam logic [DEPTH_LOG2:0] LVL_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);
  localparam logic [CNT_W-1:0]    CNT_ONE  = CNT_W'(1);

  logic [72:0]           mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [CNT_W-1:0]      pkt_cnt_q, pkt_cnt_d;
  logic                  s_ready_q, s_ready_d, m_valid_q, m_valid_d;
  logic                  push_s, pop_s;
  logic [72:0]           rd_entry_s;
`ifdef DST_FIFO_STORE_FWD_EN
  logic [DEPTH_LOG2:0]   last_cnt_q, last_cnt_d;
  logic                  fallback_q, fallback_d, sf_stall_q, sf_stall_d;
  logic                  stall_cond_s;
`endif

  // Handshakes, pointer/level/counter next-state and output valid.
  always_comb begin
    push_s     = S_AXIS_TVALID & s_ready_q;
    pop_s      = m_valid_q & M_AXIS_TREADY;
    rd_entry_s = mem_q[rd_ptr_q];
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: level_d = level_q;
    endcase
    if (pop_s && rd_entry_s[72]) begin
      pkt_cnt_d = pkt_cnt_q + CNT_ONE;
    end else begin
      pkt_cnt_d = pkt_cnt_q;
    end
    s_ready_d = (level_d != FULL_LVL);
`ifdef DST_FIFO_STORE_FWD_EN
    case ({push_s & S_AXIS_TLAST, pop_s & rd_entry_s[72]})
      2'b10:   last_cnt_d = last_cnt_q + LVL_ONE;
      2'b01:   last_cnt_d = last_cnt_q - LVL_ONE;
      default: last_cnt_d = last_cnt_q;
    endcase
    // A full FIFO with no complete packet would deadlock; stream it through instead.
    stall_cond_s = (level_q == FULL_LVL) && (last_cnt_q == LVL_ZERO);
    if (fallback_q) begin
      fallback_d = !(pop_s && rd_entry_s[72]);
    end else begin
      fallback_d = stall_cond_s;
    end
    sf_stall_d = sf_stall_q | stall_cond_s;
    m_valid_d  = (last_cnt_d != LVL_ZERO) | (fallback_d & (level_d != LVL_ZERO));
`else
    m_valid_d  = (level_d != LVL_ZERO);
`endif
  end

  // Control state; memory contents are deliberately left out of reset.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      pkt_cnt_q  <= '0;
      s_ready_q  <= 1'b0;
      m_valid_q  <= 1'b0;
`ifdef DST_FIFO_STORE_FWD_EN
      last_cnt_q <= '0;
      fallback_q <= 1'b0;
      sf_stall_q <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      pkt_cnt_q  <= pkt_cnt_d;
      s_ready_q  <= s_ready_d;
      m_valid_q  <= m_valid_d;
`ifdef DST_FIFO_STORE_FWD_EN
      last_cnt_q <= last_cnt_d;
      fallback_q <= fallback_d;
      sf_stall_q <= sf_stall_d;
`endif
    end
  end

  // Storage array write port.
  always_ff @(posedge AXIS_ACLK) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {S_AXIS_TLAST, S_AXIS_TSTRB, S_AXIS_TDATA};
    end
  end

  assign S_AXIS_TREADY = s_ready_q;
  assign M_AXIS_TVALID = m_valid_q;
  assign M_AXIS_TDATA  = rd_entry_s[63:0];
  assign M_AXIS_TSTRB  = rd_entry_s[71:64];
  assign M_AXIS_TLAST  = rd_entry_s[72];
  assign level         = level_q;
  assign pkt_cnt       = pkt_cnt_q;
`ifdef DST_FIFO_STORE_FWD_EN
  assign sf_stall      = sf_stall_q;
`else
  assign sf_stall      = 1'b0;
`endif

endmodule

// File: tb/tb_dst_fifo.sv
// Scoreboard bench for dst_fifo: beats queued on push, compared on pop.
module tb_dst_fifo;
  localparam int DL = 4;
  localparam int CW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic s_tvalid = 1'b0, s_tready, s_tlast = 1'b0;
  logic [63:0] s_tdata = 64'd0;
  logic [7:0] s_tstrb = 8'd0;
  logic m_tvalid, m_tready = 1'b0, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0] m_tstrb;
  logic [DL:0] level;
  logic [CW-1:0] pkt_cnt;
  logic sf_stall;

  dst_fifo #(.DEPTH_LOG2(DL), .CNT_W(CW)) dut (
    .AXIS_ACLK(clk), .AXIS_ARESETN(rst_n),
    .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(s_tready),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TSTRB(s_tstrb), .S_AXIS_TLAST(s_tlast),
    .M_AXIS_TVALID(m_tvalid), .M_AXIS_TREADY(m_tready),
    .M_AXIS_TDATA(m_tdata), .M_AXIS_TSTRB(m_tstrb), .M_AXIS_TLAST(m_tlast),
    .level(level), .pkt_cnt(pkt_cnt), .sf_stall(sf_stall)
  );

  always #5 clk = ~clk;

  logic [72:0] sb[$];
  int checks = 0, failures = 0;
  int m_level = 0, m_pkt = 0, n_pop = 0;
  bit pushed = 1'b0, popped = 1'b0, prev_stall = 1'b0;
  logic [72:0] prev_data = '0;

  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One cycle: check state mid-cycle, update the model, then move past the edge.
  task automatic tick();
    logic [72:0] exp_beat;
    @(negedge clk);
    chk("level", 80'(level), 80'(m_level));
    chk("s_tready", 80'(s_tready), 80'(m_level != (1 << DL)));
    chk("pkt_cnt", 80'(pkt_cnt), 80'(m_pkt % (1 << CW)));
`ifndef DST_FIFO_STORE_FWD_EN
    chk("m_tvalid", 80'(m_tvalid), 80'(m_level != 0));
    chk("sf_stall", 80'(sf_stall), 80'd0);
`endif
    if (prev_stall) begin
      chk("hold_valid", 80'(m_tvalid), 80'd1);
      chk("hold_data", 80'({m_tlast, m_tstrb, m_tdata}), 80'(prev_data));
    end
    pushed = s_tvalid && s_tready;
    popped = m_tvalid && m_tready;
    prev_stall = m_tvalid && !m_tready;
    prev_data = {m_tlast, m_tstrb, m_tdata};
    if (popped) begin
      n_pop++;
      if (sb.size() == 0) begin
        chk("pop_on_empty", 80'd1, 80'd0);
      end else begin
        exp_beat = sb.pop_front();
        chk("out_beat", 80'({m_tlast, m_tstrb, m_tdata}), 80'(exp_beat));
        if (exp_beat[72]) m_pkt++;
        m_level--;
      end
    end
    if (pushed) begin
      sb.push_back({s_tlast, s_tstrb, s_tdata});
      m_level++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic last);
    s_tdata = {$urandom(), $urandom()};
    s_tstrb = 8'($urandom());
    s_tlast = last;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s_tvalid = 1'b0;
    m_tready = 1'b0;
    #1;
    chk("rst_level", 80'(level), 80'd0);
    chk("rst_m_tvalid", 80'(m_tvalid), 80'd0);
    chk("rst_s_tready", 80'(s_tready), 80'd0);
    chk("rst_pkt_cnt", 80'(pkt_cnt), 80'd0);
    chk("rst_sf_stall", 80'(sf_stall), 80'd0);
    sb.delete();
    m_level = 0; m_pkt = 0; n_pop = 0; prev_stall = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rdy_before_edge", 80'(s_tready), 80'd0);
    @(posedge clk);
    #1;
    chk("rdy_after_edge", 80'(s_tready), 80'd1);
  endtask

  task automatic drain(input int bound);
    int n;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    n = 0;
    while (m_level != 0 && n < bound) begin
      tick();
      n++;
    end
    chk("drain_timeout", 80'(m_level), 80'd0);
  endtask

  initial begin
    int n, cyc;
    do_reset();

    // Single beat, cut-through latency of one cycle.
    m_tready = 1'b1;
    s_tvalid = 1'b1; s_tdata = 64'h0123456789ABCDEF; s_tstrb = 8'hFF; s_tlast = 1'b1;
    tick();
    s_tvalid = 1'b0;
    chk("single_valid", 80'(m_tvalid), 80'd1);
    chk("single_data", 80'(m_tdata), 80'h0123456789ABCDEF);
    tick();
    tick();
    chk("single_pkt", 80'(pkt_cnt), 80'd1);
    chk("single_level", 80'(level), 80'd0);

    // Fill to full, pop once while upstream keeps offering.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      set_beat(i == 15);
      tick();
    end
    set_beat(1'b1);
    chk("full_level", 80'(level), 80'd16);
    chk("full_s_tready", 80'(s_tready), 80'd0);
    m_tready = 1'b1;
    tick();
    m_tready = 1'b0;
    chk("after_pop_level", 80'(level), 80'd15);
    chk("after_pop_s_tready", 80'(s_tready), 80'd1);
    tick();
    drain(40);

    // 40 beats, random downstream ready, pointers wrap twice.
    s_tvalid = 1'b1;
    n = 0; cyc = 0;
    set_beat(1'b0);
    while (n < 40 && cyc < 600) begin
      m_tready = 1'($urandom_range(0, 1));
      tick();
      cyc++;
      if (pushed) begin
        n++;
        set_beat((n % 8) == 7);
      end
    end
    chk("stream_timeout", 80'(n), 80'd40);
    drain(60);

    // Single-beat packets to wrap the narrow packet counter.
    s_tvalid = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      set_beat(1'b1);
      tick();
    end
    drain(20);

`ifdef DST_FIFO_STORE_FWD_EN
    // Output held back until the whole packet is stored.
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_beat(i == 2);
      chk("sf_hold_off", 80'(m_tvalid), 80'd0);
      tick();
    end
    s_tvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sf_back_to_back", 80'(popped), 80'd1);
    end
    // Oversized packet falls back to cut-through.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    n = 0;
    set_beat(1'b0);
    while (n < 16) begin
      tick();
      n++;
      set_beat(1'b0);
    end
    tick();
    chk("sf_stall_set", 80'(sf_stall), 80'd1);
    m_tready = 1'b1;
    cyc = 0;
    while (n < 20 && cyc < 100) begin
      tick();
      cyc++;
      if (pushed) begin
        n++;
        set_beat(n == 19);
      end
    end
    chk("sf_push_timeout", 80'(n), 80'd20);
    drain(40);
`endif

    // Reset in the middle of a packet discards it.
    m_tready = 1'b0;
    s_tvalid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_beat(1'b0);
      tick();
    end
    do_reset();
    s_tvalid = 1'b1;
    m_tready = 1'b0;
    set_beat(1'b0);
    tick();
    set_beat(1'b1);
    tick();
    drain(20);
    tick();
    chk("post_rst_pops", 80'(n_pop), 80'd2);
    chk("post_rst_pkt", 80'(pkt_cnt), 80'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
